pic_irq_ctrl: RTL
=================

Name: pic_irq_ctrl

Overview:
- Simplified 8259A-style programmable interrupt controller, directly downstream of the 8253 timer.
- Takes eight IRQ lines: IR0 is driven by timer OUT0, IR1..IR7 by other peripherals.
- Latches rising edges on those lines, prioritises them, raises INT to the CPU and supplies the interrupt vector during the two-pulse INTA_ handshake.
- Fully synchronous to one clock; bus strobes and IRQ inputs are sampled, not used as clocks.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each IR input and on RD_/WR_/INTA_ before edge detection (minimum 2).
- SPURIOUS_IR, 7, IR level whose vector is returned when INTA_ finds nothing pending.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RESET_  input  1  reset, asynchronous and active-low.
- CS_  input  1  chip select, active low.
- A0  input  1  register address.
- RD_  input  1  read strobe, active low.
- WR_  input  1  write strobe, active low.
- DIN  input  8  data from CPU bus.
- DOUT  output  8  data to CPU bus.
- DOE  output  1  DOUT valid / drive enable.
- IR  input  8  interrupt requests; IR[0] = timer OUT0.
- INTA_  input  1  interrupt acknowledge, active low.
- INT  output  1  interrupt request to CPU, active high.

Behaviour:
- Reset: INT=0, DOE=0, DOUT=0. IRR=ISR=0, IMR=8'hFF, VBASE=0. Read select = IRR. Init FSM = UNINIT; ack FSM = IDLE.
- Write commit: occurs on the synchronised rising edge of WR_ while CS_=0 and RD_=1.
  - A0=0, DIN[4]=1: ICW1. Latch IC4=DIN[0]. Clear IRR, ISR and edge history; IMR=8'h00; read select = IRR. Go to WAIT_ICW2. Legal from any state, including mid-operation.
  - WAIT_ICW2, A0=1: VBASE=DIN[7:3]. Go to WAIT_ICW4 if IC4=1, else READY.
  - WAIT_ICW4, A0=1: contents ignored (8086 mode fixed). Go to READY.
  - READY, A0=1: OCW1, IMR=DIN.
  - READY, A0=0, DIN[4:3]=00: OCW2, decoded from DIN[7:5].
    - 001: non-specific EOI; clear the lowest-numbered set ISR bit.
    - 011: specific EOI; clear ISR[DIN[2:0]].
    - Other encodings: ignored.
  - READY, A0=0, DIN[4:3]=01: OCW3. If DIN[1]=1, read select = DIN[0] ? ISR : IRR.
  - Writes in UNINIT other than ICW1: ignored.
- Read: while CS_=0 and RD_=0 (synchronised), DOE=1.
  - A0=1: DOUT=IMR.
  - A0=0: DOUT=IRR or ISR per read select.
  - Combinational from the current registers; DOE deasserts one CLK after RD_ returns high.
- IRR: bit n sets on a synchronised 0->1 transition of IR[n]; edge-triggered only.
  - Setting an already-set bit has no effect.
  - Clearing at acknowledge wins over a simultaneous set on the same bit; that edge is lost, which matches hardware.
- Priority: fixed, IR0 highest.
  - pend = IRR & ~IMR.
  - INT=1 (registered) iff state=READY, ack FSM=IDLE, and the lowest set bit of pend is below the lowest set bit of ISR (any pend bit when ISR=0).
- Ack FSM (on synchronised INTA_):
  - IDLE: on INTA_ falling edge, select the winner n = lowest-numbered pend bit not blocked by ISR. Set ISR[n], clear IRR[n], store n. If none, store SPURIOUS_IR and flag spurious (ISR unchanged). INT drops the next cycle. Go to ACK1.
  - ACK1: on INTA_ rising edge go to WAIT2.
  - WAIT2: on INTA_ falling edge go to ACK2.
  - ACK2: DOE=1, DOUT={VBASE, n}. On INTA_ rising edge clear the spurious flag, DOE=0, go to IDLE.
  - INTA_ has precedence over RD_ when both are low.
- ICW1 during any ack state forces the ack FSM to IDLE and DOE=0.
- IMR changes take effect on INT in the cycle after the OCW1 commit; already latched ISR bits are unaffected.

Decomposition:
- Shared package pic_pkg:
  - Init FSM state encoding (UNINIT, WAIT_ICW2, WAIT_ICW4, READY).
  - Ack FSM encoding (IDLE, ACK1, WAIT2, ACK2).
  - OCW2 command constants (EOI_NS=3'b001, EOI_SP=3'b011).
  - Function lowest_set(8-bit) returning {valid, index[2:0]}.
- One sub-module, pic_edge_sync: SYNC_STAGES synchroniser plus rising/falling-edge pulse generator, instantiated for IR[7:0], RD_, WR_ and INTA_.

Test Plan:
- Init ICW1=8'h13, ICW2=8'h08, ICW4=8'h01, OCW1=8'hFE; pulse IR0 -> INT=1 within SYNC_STAGES+2 clocks; INTA_ pair -> DOUT=8'h08 with DOE=1 in second pulse; ISR=8'h01, IRR=0.
- IR0 still in service, IR3 unmasked and pulsed -> INT stays 0; OCW2=8'h20 (non-specific EOI) -> ISR=0, INT=1, next ack vector 8'h0B.
- IR5 and IR2 rise on the same clock, IMR=0 -> first ack vector VBASE|2; after EOI, second ack vector VBASE|5.
- Request latched, OCW1=8'hFF before ack -> INT=0 next cycle; read A0=1 returns 8'hFF; OCW3=8'h0A then read A0=0 returns IRR with the pending bit set.
- INTA_ pair with nothing pending -> vector VBASE|7, ISR unchanged; IR1 held high with no new edge -> no second INT.
- RESET_ low mid ACK2 -> DOE=0 and INT=0 asynchronously, IMR=8'hFF; post-reset writes other than ICW1 are ignored.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types, command codes and helpers for the interrupt controller.
package pic_pkg;

    // Initialisation sequence: ICW1 -> ICW2 -> (optional ICW4) -> operational.
    typedef enum logic [1:0] {
        UNINIT    = 2'd0,
        WAIT_ICW2 = 2'd1,
        WAIT_ICW4 = 2'd2,
        READY     = 2'd3
    } init_state_t;

    // Two-pulse INTA_ handshake tracking.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK1  = 2'd1,
        WAIT2 = 2'd2,
        ACK2  = 2'd3
    } ack_state_t;

    // OCW2 command field DIN[7:5].
    localparam logic [2:0] EOI_NS = 3'b001;
    localparam logic [2:0] EOI_SP = 3'b011;

    // DIN[4:3] selector for A0=0 writes once operational.
    localparam logic [1:0] OCW_SEL_OCW2 = 2'b00;
    localparam logic [1:0] OCW_SEL_OCW3 = 2'b01;

    // Lowest-numbered set bit: {valid, index}. Bit 0 is highest priority.
    function automatic logic [3:0] lowest_set(input logic [7:0] vec);
        logic [3:0] res;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pic_edge_sync.sv
// Multi-stage synchroniser with rising/falling edge pulse generation.
// STAGES must be at least 2. hist_clr forces the edge history high so a
// line that is already high must drop and rise again to produce a new rise.
module pic_edge_sync #(
    parameter int               STAGES  = 2,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             hist_clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;
    logic [STAGES-1:0][WIDTH-1:0] chain_d;
    logic [WIDTH-1:0]             prev_q;
    logic [WIDTH-1:0]             prev_d;

    genvar gi;

    assign chain_d[0] = din;
    generate
        for (gi = 1; gi < STAGES; gi++) begin : g_chain
            assign chain_d[gi] = chain_q[gi-1];
        end
    endgenerate

    // Edge history: last synchronised value, or all-ones when being cleared.
    always_comb begin
        prev_d = chain_q[STAGES-1];
        if (hist_clr) begin
            prev_d = '1;
        end
    end

    // Synchroniser chain and history register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign level = chain_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/pic_irq_ctrl.sv
// Simplified 8259A-style interrupt controller: edge-latched requests,
// fixed priority (IR0 highest), ICW/OCW programming and INTA_ vectoring.
module pic_irq_ctrl
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SPURIOUS_IR = 7
) (
    input  logic       CLK,
    input  logic       RESET_,
    input  logic       CS_,
    input  logic       A0,
    input  logic       RD_,
    input  logic       WR_,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    output logic       DOE,
    input  logic [7:0] IR,
    input  logic       INTA_,
    output logic       INT
);

    localparam logic [2:0] SPUR_IDX = 3'(SPURIOUS_IR);

    // Synchronised views of the asynchronous inputs
    logic [7:0] ir_level, ir_rise, ir_fall;
    logic       rd_s, rd_rise, rd_fall;
    logic       wr_s, wr_rise, wr_fall;
    logic       inta_s, inta_rise, inta_fall;
    logic       hist_clr;

    // Architectural state
    init_state_t init_state_q, init_state_d;
    ack_state_t  ack_state_q, ack_state_d;
    logic [7:0]  irr_q, irr_d;
    logic [7:0]  isr_q, isr_d;
    logic [7:0]  imr_q, imr_d;
    logic [4:0]  vbase_q, vbase_d;
    logic        ic4_q, ic4_d;
    logic        rsel_isr_q, rsel_isr_d;
    logic [2:0]  vec_q, vec_d;
    logic        spurious_q, spurious_d;
    logic        int_q, int_d;

    // Decode helpers
    logic       wr_commit;
    logic       is_icw1;
    logic [3:0] lo_pend;
    logic [3:0] lo_isr;
    logic       win_valid;
    logic [3:0] lo_pend_d;
    logic [3:0] lo_isr_d;

    pic_edge_sync #(.STAGES(SYNC_STAGES), .WIDTH(8), .RST_VAL(8'h00)) u_sync_ir (
        .clk(CLK), .rst_n(RESET_), .din(IR), .hist_clr(hist_clr),
        .level(ir_level), .rise(ir_rise), .fall(ir_fall)
    );

    pic_edge_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1)) u_sync_rd (
        .clk(CLK), .rst_n(RESET_), .din(RD_), .hist_clr(1'b0),
        .level(rd_s), .rise(rd_rise), .fall(rd_fall)
    );

    pic_edge_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1)) u_sync_wr (
        .clk(CLK), .rst_n(RESET_), .din(WR_), .hist_clr(1'b0),
        .level(wr_s), .rise(wr_rise), .fall(wr_fall)
    );

    pic_edge_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1)) u_sync_inta (
        .clk(CLK), .rst_n(RESET_), .din(INTA_), .hist_clr(1'b0),
        .level(inta_s), .rise(inta_rise), .fall(inta_fall)
    );

    // Synchroniser outputs this block has no use for.
    logic unused_bits;
    assign unused_bits = ^{ir_level, ir_fall, rd_rise, rd_fall, wr_s, wr_fall};

    // A write lands on the end of the WR_ strobe, only when not reading.
    assign wr_commit = wr_rise & ~CS_ & rd_s;
    assign is_icw1   = wr_commit & ~A0 & DIN[4];
    assign hist_clr  = is_icw1;

    // Priority resolution on current state: a request wins only if it is
    // strictly higher priority than everything already in service.
    always_comb begin
        lo_pend   = lowest_set(irr_q & ~imr_q);
        lo_isr    = lowest_set(isr_q);
        win_valid = (init_state_q == READY) && lo_pend[3] &&
                    (!lo_isr[3] || (lo_pend[2:0] < lo_isr[2:0]));
    end

    // Next-state: request latching, ack handshake, then bus writes.
    always_comb begin
        init_state_d = init_state_q;
        ack_state_d  = ack_state_q;
        irr_d        = irr_q | ir_rise;
        isr_d        = isr_q;
        imr_d        = imr_q;
        vbase_d      = vbase_q;
        ic4_d        = ic4_q;
        rsel_isr_d   = rsel_isr_q;
        vec_d        = vec_q;
        spurious_d   = spurious_q;
        int_d        = 1'b0;
        lo_pend_d    = 4'b0000;
        lo_isr_d     = 4'b0000;

        case (ack_state_q)
            IDLE: begin
                if (inta_fall) begin
                    ack_state_d = ACK1;
                    if (win_valid) begin
                        // Acknowledge clear overrides a same-cycle new edge.
                        isr_d[lo_pend[2:0]] = 1'b1;
                        irr_d[lo_pend[2:0]] = 1'b0;
                        vec_d               = lo_pend[2:0];
                        spurious_d          = 1'b0;
                    end else begin
                        spurious_d = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta_rise) begin
                    ack_state_d = WAIT2;
                end
            end
            WAIT2: begin
                if (inta_fall) begin
                    ack_state_d = ACK2;
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    ack_state_d = IDLE;
                    spurious_d  = 1'b0;
                end
            end
            default: ack_state_d = IDLE;
        endcase

        if (is_icw1) begin
            // Re-initialisation aborts anything in flight.
            ic4_d        = DIN[0];
            irr_d        = 8'h00;
            isr_d        = 8'h00;
            imr_d        = 8'h00;
            rsel_isr_d   = 1'b0;
            init_state_d = WAIT_ICW2;
            ack_state_d  = IDLE;
            spurious_d   = 1'b0;
        end else if (wr_commit) begin
            case (init_state_q)
                WAIT_ICW2: begin
                    if (A0) begin
                        vbase_d      = DIN[7:3];
                        init_state_d = ic4_q ? WAIT_ICW4 : READY;
                    end
                end
                WAIT_ICW4: begin
                    if (A0) begin
                        init_state_d = READY;
                    end
                end
                READY: begin
                    if (A0) begin
                        imr_d = DIN;
                    end else if (DIN[4:3] == OCW_SEL_OCW2) begin
                        if (DIN[7:5] == EOI_NS) begin
                            if (lo_isr[3]) begin
                                isr_d[lo_isr[2:0]] = 1'b0;
                            end
                        end else if (DIN[7:5] == EOI_SP) begin
                            isr_d[DIN[2:0]] = 1'b0;
                        end
                    end else if (DIN[4:3] == OCW_SEL_OCW3) begin
                        if (DIN[1]) begin
                            rsel_isr_d = DIN[0];
                        end
                    end
                end
                default: ;
            endcase
        end

        // INT tracks the registers it will sit beside after this edge.
        lo_pend_d = lowest_set(irr_d & ~imr_d);
        lo_isr_d  = lowest_set(isr_d);
        int_d     = (init_state_d == READY) && (ack_state_d == IDLE) &&
                    lo_pend_d[3] &&
                    (!lo_isr_d[3] || (lo_pend_d[2:0] < lo_isr_d[2:0]));
    end

    // State registers.
    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_) begin
            init_state_q <= UNINIT;
            ack_state_q  <= IDLE;
            irr_q        <= 8'h00;
            isr_q        <= 8'h00;
            imr_q        <= 8'hFF;
            vbase_q      <= 5'd0;
            ic4_q        <= 1'b0;
            rsel_isr_q   <= 1'b0;
            vec_q        <= 3'd0;
            spurious_q   <= 1'b0;
            int_q        <= 1'b0;
        end else begin
            init_state_q <= init_state_d;
            ack_state_q  <= ack_state_d;
            irr_q        <= irr_d;
            isr_q        <= isr_d;
            imr_q        <= imr_d;
            vbase_q      <= vbase_d;
            ic4_q        <= ic4_d;
            rsel_isr_q   <= rsel_isr_d;
            vec_q        <= vec_d;
            spurious_q   <= spurious_d;
            int_q        <= int_d;
        end
    end

    assign INT = int_q;

    // Bus output: vector during the second INTA_ pulse, else register reads.
    always_comb begin
        DOE  = 1'b0;
        DOUT = 8'h00;
        if (ack_state_q == ACK2) begin
            DOE  = 1'b1;
            DOUT = {vbase_q, (spurious_q ? SPUR_IDX : vec_q)};
        end else if (inta_s && !CS_ && !rd_s) begin
            DOE = 1'b1;
            if (A0) begin
                DOUT = imr_q;
            end else begin
                DOUT = rsel_isr_q ? isr_q : irr_q;
            end
        end
    end

endmodule
